cd_spi_csr_bridge: RTL and testbench

SPI slave (mode 0, CPOL=0/CPHA=0) that acts as the initiator on the 8-bit CSR bus: csr_address/csr_read/csr_write/csr_writedata out, csr_readdata in.
Lets an external MCU reach the CDBUS controller registers over SPI.
SPI pins are oversampled in the clk domain; each SPI frame is one header byte followed by a burst of data bytes.

---
 rtl/cd_spi_csr_bridge.sv | 151 +++++++++++++++
 tb/tb_cd_spi_csr_bridge.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_spi_csr_bridge.sv
// SPI mode-0 slave bridging an external MCU onto the 8-bit CSR bus (header byte + data burst).
// Optional SPI_ADDR_INC_EN: csr_address post-increments after every strobe.
module cd_spi_csr_bridge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       nss,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [4:0] csr_address,
    output logic       csr_read,
    output logic       csr_write,
    output logic [7:0] csr_writedata,
    input  logic [7:0] csr_readdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        WR_DATA = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] nss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_q;
    logic                   nss_q;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;

    logic       sck_s;
    logic       nss_s;
    logic       mosi_s;
    logic       sck_rise;
    logic       sck_fall;
    logic       nss_fall;
    logic [7:0] rx_next;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign nss_s    = nss_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign nss_fall = ~nss_s & nss_q;
    assign rx_next  = {rx_sr, mosi_s};

    // Oversampling synchronizers plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            nss_sync  <= '0;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
            nss_q     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            nss_sync  <= {nss_sync[SYNC_STAGES-2:0], nss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_q     <= sck_s;
            nss_q     <= nss_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            rx_sr         <= 7'd0;
            tx_sr         <= 8'd0;
            miso          <= 1'b0;
            miso_oe       <= 1'b0;
            csr_address   <= 5'd0;
            csr_read      <= 1'b0;
            csr_write     <= 1'b0;
            csr_writedata <= 8'd0;
        end else begin
            csr_read  <= 1'b0;
            csr_write <= 1'b0;
`ifdef SPI_ADDR_INC_EN
            if (csr_read || csr_write) begin
                csr_address <= csr_address + 5'd1;
            end
`endif
            // Deselect wins over any edge seen in the same clk; a partial byte is dropped.
            if (state != IDLE && nss_s) begin
                state   <= IDLE;
                bit_cnt <= 3'd0;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (nss_fall) begin
                            state   <= HDR;
                            bit_cnt <= 3'd0;
                            miso    <= 1'b0;
                            miso_oe <= 1'b1;
                        end
                    end
                    HDR: begin
                        if (sck_rise) begin
                            rx_sr   <= rx_next[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                csr_address <= rx_next[4:0];
                                state       <= rx_next[7] ? WR_DATA : RD_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (sck_rise) begin
                            rx_sr   <= rx_next[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                csr_writedata <= rx_next;
                                csr_write     <= 1'b1;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (sck_rise) begin
                            rx_sr   <= rx_next[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                csr_read <= 1'b1;
                            end
                        end else if (sck_fall) begin
                            // The fall at a byte boundary loads fresh read data; later falls shift.
                            if (bit_cnt == 3'd0) begin
                                tx_sr <= {csr_readdata[6:0], 1'b0};
                                miso  <= csr_readdata[7];
                            end else begin
                                tx_sr <= {tx_sr[6:0], 1'b0};
                                miso  <= tx_sr[7];
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cd_spi_csr_bridge.sv
// Self-checking bench for cd_spi_csr_bridge: randomized SPI frames against a transaction-level model.
`timescale 1ns/1ps
module tb_cd_spi_csr_bridge;

    localparam int unsigned SYNC = 2;
    localparam int HMIN = (SYNC + 4) * 10;
`ifdef SPI_ADDR_INC_EN
    localparam int INC = 1;
`else
    localparam int INC = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sck = 1'b0;
    logic       nss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [4:0] csr_address;
    logic       csr_read;
    logic       csr_write;
    logic [7:0] csr_writedata;
    logic [7:0] csr_readdata;

    cd_spi_csr_bridge #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .sck(sck), .nss(nss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .csr_address(csr_address),
        .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata)
    );

    always #5 clk = ~clk;

    // CSR target: plain register file, or a FIFO-style read port whose pointer advances on csr_read.
    logic [7:0] regs [32];
    logic [7:0] ram [256];
    logic [7:0] rd_ptr = 8'd0;
    logic       fifo_mode = 1'b0;
    logic       ptr_clr = 1'b0;
    assign csr_readdata = fifo_mode ? ram[rd_ptr] : regs[csr_address];
    always_ff @(posedge clk) begin
        if (ptr_clr) rd_ptr <= 8'd0;
        else if (csr_read) rd_ptr <= rd_ptr + 8'd1;
    end

    typedef struct packed { logic [4:0] a; logic [7:0] d; } wr_t;
    wr_t        wr_q [$];
    logic [4:0] rd_q [$];
    int         overlap = 0;
    always @(negedge clk) begin
        if (csr_write) wr_q.push_back({csr_address, csr_writedata});
        if (csr_read) rd_q.push_back(csr_address);
        if (csr_read && csr_write) overlap <= overlap + 1;
    end

    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  tx_buf [16];
    logic [7:0]  rx_buf [16];
    logic        oe_mid;
    logic        oe_end;
    logic [22:0] rst_snap;

    function automatic logic [4:0] exp_addr(input logic [4:0] base, input int k);
        return base + 5'(k * INC);
    endfunction

    // SPI master: mosi set while sck low, miso sampled just before each rise.
    task automatic spi_frame(input int nbits, input int h, input int reset_at);
        nss = 1'b0;
        #(h);
        for (int j = 0; j < nbits; j++) begin
            int b;
            int i;
            b = j / 8;
            i = 7 - (j % 8);
            mosi = tx_buf[b][i];
            #(h);
            rx_buf[b][i] = miso;
            if (j == 4) oe_mid = miso_oe;
            sck = 1'b1;
            if (j == reset_at) begin
                #15 reset = 1'b1;
                #2 rst_snap = {miso, miso_oe, csr_address, csr_read, csr_write, csr_writedata};
                #20 reset = 1'b0;
                #(h - 37);
            end else begin
                #(h);
            end
            sck = 1'b0;
        end
        #(h);
        oe_end = miso_oe;
        nss = 1'b1;
        mosi = 1'b0;
        repeat (12) @(posedge clk);
        #3;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        n_tests++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got=%0b exp=0", miso); end
        n_tests++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe got=%0b exp=0", miso_oe); end
        n_tests++; if (csr_address !== 5'd0) begin n_fail++; $display("FAIL reset_addr got=%h exp=00", csr_address); end
        n_tests++; if ({csr_read, csr_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got=%b exp=00", {csr_read, csr_write}); end
        n_tests++; if (csr_writedata !== 8'd0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=00", csr_writedata); end
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        n_tests++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL idle_miso_oe got=%0b exp=0", miso_oe); end
    endtask

    task automatic test_write_burst();
        for (int t = 0; t < 7; t++) begin
            int n;
            int h;
            logic [7:0] hdr;
            if (t == 0) begin
                hdr = 8'h95; n = 3; h = 80;
                tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
            end else begin
                hdr = {1'b1, 2'($urandom), 5'($urandom)};
                n = $urandom_range(1, 4);
                h = HMIN + $urandom_range(0, 37);
                for (int k = 0; k < n; k++) tx_buf[k+1] = 8'($urandom);
            end
            tx_buf[0] = hdr;
            wr_q.delete(); rd_q.delete();
            spi_frame(8 * (n + 1), h, -1);
            n_tests++;
            if (wr_q.size() !== n || rd_q.size() !== 0) begin
                n_fail++; $display("FAIL wr_count hdr=%h got_wr=%0d got_rd=%0d exp_wr=%0d exp_rd=0", hdr, wr_q.size(), rd_q.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    n_tests++;
                    if (wr_q[k] !== {exp_addr(hdr[4:0], k), tx_buf[k+1]}) begin
                        n_fail++; $display("FAIL wr_data k=%0d got=%h/%h exp=%h/%h", k, wr_q[k].a, wr_q[k].d, exp_addr(hdr[4:0], k), tx_buf[k+1]);
                    end
                end
            end
        end
    endtask

    task automatic test_read();
        fifo_mode = 1'b0;
        regs[0] = 8'h0e;
        tx_buf[0] = 8'h00; tx_buf[1] = 8'hff;
        wr_q.delete(); rd_q.delete();
        spi_frame(16, 70, -1);
        n_tests++; if (rx_buf[0] !== 8'h00) begin n_fail++; $display("FAIL rd_hdr_miso got=%h exp=00", rx_buf[0]); end
        n_tests++; if (rx_buf[1] !== 8'h0e) begin n_fail++; $display("FAIL rd_miso got=%h exp=0e", rx_buf[1]); end
        n_tests++; if (oe_mid !== 1'b1) begin n_fail++; $display("FAIL rd_oe_mid got=%0b exp=1", oe_mid); end
        n_tests++;
        if (rd_q.size() !== 1 || wr_q.size() !== 0) begin
            n_fail++; $display("FAIL rd_count got_rd=%0d got_wr=%0d exp=1/0", rd_q.size(), wr_q.size());
        end else if (rd_q[0] !== 5'd0) begin
            n_fail++; $display("FAIL rd_addr got=%h exp=00", rd_q[0]);
        end
        n_tests++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL rd_oe_after got=%0b exp=0", miso_oe); end
    endtask

    task automatic test_read_burst();
        for (int t = 0; t < 6; t++) begin
            int n;
            int h;
            logic [7:0] hdr;
            logic [7:0] exp_b;
            for (int k = 0; k < 32; k++) regs[k] = 8'($urandom);
            for (int k = 0; k < 8; k++) ram[k] = 8'($urandom);
            if (t == 0) begin
                fifo_mode = 1'b1; hdr = 8'h14; n = 4; h = 75;
                ptr_clr = 1'b1; @(posedge clk); #1 ptr_clr = 1'b0;
            end else begin
                fifo_mode = 1'b0;
                hdr = {1'b0, 2'($urandom), 5'($urandom)};
                n = $urandom_range(1, 4);
                h = HMIN + $urandom_range(0, 37);
            end
            tx_buf[0] = hdr;
            for (int k = 0; k < n; k++) tx_buf[k+1] = 8'($urandom);
            wr_q.delete(); rd_q.delete();
            spi_frame(8 * (n + 1), h, -1);
            n_tests++;
            if (rd_q.size() !== n || wr_q.size() !== 0) begin
                n_fail++; $display("FAIL rdb_count hdr=%h got_rd=%0d got_wr=%0d exp_rd=%0d", hdr, rd_q.size(), wr_q.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    exp_b = fifo_mode ? ram[k] : regs[exp_addr(hdr[4:0], k)];
                    n_tests++;
                    if (rx_buf[k+1] !== exp_b || rd_q[k] !== exp_addr(hdr[4:0], k)) begin
                        n_fail++; $display("FAIL rdb_byte k=%0d got=%h@%h exp=%h@%h", k, rx_buf[k+1], rd_q[k], exp_b, exp_addr(hdr[4:0], k));
                    end
                end
            end
        end
        fifo_mode = 1'b0;
    endtask

    task automatic test_abort();
        tx_buf[0] = 8'h82; tx_buf[1] = 8'h5a; tx_buf[2] = 8'($urandom);
        wr_q.delete(); rd_q.delete();
        spi_frame(21, 70, -1);
        n_tests++;
        if (wr_q.size() !== 1 || rd_q.size() !== 0) begin
            n_fail++; $display("FAIL abort_count got_wr=%0d got_rd=%0d exp=1/0", wr_q.size(), rd_q.size());
        end else if (wr_q[0] !== {5'h02, 8'h5a}) begin
            n_fail++; $display("FAIL abort_data got=%h/%h exp=02/5a", wr_q[0].a, wr_q[0].d);
        end
        n_tests++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL abort_oe got=%0b exp=0", miso_oe); end
        tx_buf[0] = 8'h83; tx_buf[1] = 8'h77;
        wr_q.delete();
        spi_frame(16, 70, -1);
        n_tests++;
        if (wr_q.size() !== 1 || wr_q[0] !== {5'h03, 8'h77}) begin
            n_fail++; $display("FAIL abort_recover got_n=%0d exp=1 (03/77)", wr_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        tx_buf[0] = 8'h84; tx_buf[1] = 8'hc3;
        wr_q.delete(); rd_q.delete();
        spi_frame(16, 80, 10);
        n_tests++; if (rst_snap !== 23'd0) begin n_fail++; $display("FAIL rstmid_outputs got=%h exp=0", rst_snap); end
        n_tests++;
        if (wr_q.size() !== 0 || rd_q.size() !== 0) begin
            n_fail++; $display("FAIL rstmid_strobes got_wr=%0d got_rd=%0d exp=0/0", wr_q.size(), rd_q.size());
        end
        n_tests++; if (oe_end !== 1'b0) begin n_fail++; $display("FAIL rstmid_oe got=%0b exp=0", oe_end); end
        tx_buf[0] = 8'h84; tx_buf[1] = 8'h0a;
        spi_frame(16, 80, -1);
        n_tests++;
        if (wr_q.size() !== 1 || wr_q[0] !== {5'h04, 8'h0a}) begin
            n_fail++; $display("FAIL rstmid_next got_n=%0d exp=1 (04/0a)", wr_q.size());
        end
    endtask

    task automatic test_min_timing();
        for (int t = 0; t < 3; t++) begin
            logic [4:0] a;
            #($urandom_range(1, 9));
            a = 5'($urandom);
            tx_buf[0] = {3'b100, a};
            for (int k = 1; k < 5; k++) tx_buf[k] = 8'($urandom);
            wr_q.delete(); rd_q.delete();
            spi_frame(40, HMIN, -1);
            n_tests++;
            if (wr_q.size() !== 4) begin
                n_fail++; $display("FAIL min_wr_count got=%0d exp=4", wr_q.size());
            end else begin
                for (int k = 0; k < 4; k++) begin
                    n_tests++;
                    if (wr_q[k] !== {exp_addr(a, k), tx_buf[k+1]}) begin
                        n_fail++; $display("FAIL min_wr k=%0d got=%h/%h exp=%h/%h", k, wr_q[k].a, wr_q[k].d, exp_addr(a, k), tx_buf[k+1]);
                    end
                end
            end
            #($urandom_range(1, 9));
            for (int k = 0; k < 32; k++) regs[k] = 8'($urandom);
            tx_buf[0] = {3'b000, a};
            wr_q.delete(); rd_q.delete();
            spi_frame(40, HMIN, -1);
            n_tests++;
            if (rd_q.size() !== 4) begin
                n_fail++; $display("FAIL min_rd_count got=%0d exp=4", rd_q.size());
            end else begin
                for (int k = 0; k < 4; k++) begin
                    n_tests++;
                    if (rx_buf[k+1] !== regs[exp_addr(a, k)]) begin
                        n_fail++; $display("FAIL min_rd k=%0d got=%h exp=%h", k, rx_buf[k+1], regs[exp_addr(a, k)]);
                    end
                end
            end
        end
    endtask

    task automatic test_strobe_exclusive();
        n_tests++;
        if (overlap !== 0) begin n_fail++; $display("FAIL strobe_overlap got=%0d exp=0", overlap); end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) regs[k] = 8'($urandom);
        for (int k = 0; k < 256; k++) ram[k] = 8'($urandom);
        test_reset();
        test_write_burst();
        test_read();
        test_read_burst();
        test_abort();
        test_reset_midframe();
        test_min_timing();
        test_strobe_exclusive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
